// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and default sizes for the LFSR sequencer.
package lfsr_ctrl_pkg;

  localparam int LENGTH_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    CAPTURE
  } state_t;

endpackage

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that owns the rst/d/fb pins of an external simpleLFSR.
// It clears the LFSR, loads a seed MSB first, runs feedback for a
// programmed number of cycles, then captures the final state.
module lfsr_seq_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LENGTH-1:0] seed,
  input  logic [CNT_W-1:0]  run_len,
  input  logic [LENGTH-1:0] lfsr_state,
  output logic              lfsr_rst,
  output logic              lfsr_d,
  output logic              lfsr_fb,
  output logic              busy,
  output logic              done,
  output logic [LENGTH-1:0] result,
  output logic              seed_err
);

  // Load counter width; a 1-bit LFSR still needs a 1-bit counter.
  localparam int BW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(LENGTH - 1);

  state_t              state_reg, state_next;
  logic [LENGTH-1:0]   seed_q;
  logic [CNT_W-1:0]    run_len_q;
  logic [CNT_W-1:0]    run_cnt_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic [BW-1:0]       bit_idx;
  logic [LENGTH-1:0]   result_reg;
  logic                done_reg;
  logic                seed_err_reg;
  logic                start_ok;

  // A zero seed would lock the LFSR in the all-zero state, so it is refused.
  assign start_ok = start && (seed != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort only cancels CLEAR/LOAD/RUN, CAPTURE always completes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) state_next = CLEAR;
      end
      CLEAR: begin
        state_next = abort ? IDLE : LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (bit_cnt_reg == LAST_BIT) begin
          state_next = (run_len_q != '0) ? RUN : CAPTURE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (run_cnt_reg == CNT_W'(1)) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand latches, counters, result capture and pulse flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q       <= '0;
      run_len_q    <= '0;
      run_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      result_reg   <= '0;
      done_reg     <= 1'b0;
      seed_err_reg <= 1'b0;
    end else begin
      done_reg     <= (state_reg == CAPTURE);
      seed_err_reg <= (state_reg == IDLE) && start && (seed == '0);
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            seed_q      <= seed;
            run_len_q   <= run_len;
            run_cnt_reg <= run_len;
          end
        end
        CLEAR: begin
          bit_cnt_reg <= '0;
        end
        LOAD: begin
          bit_cnt_reg <= bit_cnt_reg + BW'(1);
        end
        RUN: begin
          // Saturate at zero so the counter can never wrap.
          if (run_cnt_reg != '0) run_cnt_reg <= run_cnt_reg - CNT_W'(1);
        end
        CAPTURE: begin
          result_reg <= lfsr_state;
        end
        default: begin
        end
      endcase
    end
  end

  // Seed is presented MSB first so it ends up in natural order after the shifts.
  assign bit_idx  = LAST_BIT - bit_cnt_reg;

  // All LFSR controls and status decode from registers only.
  assign lfsr_rst = (state_reg == CLEAR);
  assign lfsr_fb  = (state_reg == RUN);
  assign lfsr_d   = (state_reg == LOAD) ? seed_q[bit_idx] : 1'b0;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign result   = result_reg;
  assign seed_err = seed_err_reg;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl driving a maximal-length 8-bit simpleLFSR.

// 8-bit Fibonacci LFSR, taps 8,6,5,4; shifts toward the MSB.
module simpleLFSR #(
  parameter int LENGTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic              fb,
  output logic [LENGTH-1:0] state
);
  // Shift register with synchronous clear; fb selects feedback over serial input.
  always_ff @(posedge clk) begin
    if (rst) state <= '0;
    else     state <= {state[LENGTH-2:0], fb ? (state[7] ^ state[5] ^ state[4] ^ state[3]) : d};
  end
endmodule

module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  seed;
  logic [15:0] run_len;
  logic [7:0]  lfsr_state;
  logic        lfsr_rst, lfsr_d, lfsr_fb, busy, done, seed_err;
  logic [7:0]  result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simpleLFSR #(.LENGTH(8)) u_lfsr (
    .clk(clk), .rst(lfsr_rst), .d(lfsr_d), .fb(lfsr_fb), .state(lfsr_state)
  );

  lfsr_seq_ctrl #(.LENGTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
    .run_len(run_len), .lfsr_state(lfsr_state), .lfsr_rst(lfsr_rst),
    .lfsr_d(lfsr_d), .lfsr_fb(lfsr_fb), .busy(busy), .done(done),
    .result(result), .seed_err(seed_err)
  );

  // Reference: n feedback steps of the maximal-length 8-bit LFSR.
  function automatic logic [7:0] ref_steps(input logic [7:0] s, input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one start and wait (bounded) for done; dcyc = -1 on timeout.
  task automatic do_op(input logic [7:0] s, input logic [15:0] r, input int budget,
                       output int dcyc, output logic [7:0] res, output logic busy_at_done);
    seed = s; run_len = r; start = 1'b1;
    tick;
    start = 1'b0;
    dcyc = -1; res = 8'h00; busy_at_done = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (done === 1'b1) begin
        dcyc = c; res = result; busy_at_done = busy;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    logic [5:0] outs;
    rst = 1'b1;
    tick; tick;
    outs = {busy, done, seed_err, lfsr_rst, lfsr_d, lfsr_fb};
    checks++;
    if (outs !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b required 000000", outs);
    end
    checks++;
    if (result !== 8'h00) begin
      errors++; $display("FAIL reset_result got %h required 00", result);
    end
    rst = 1'b0;
    tick;
    $display("reset: busy=%b result=%h", busy, result);
  endtask

  task automatic test_load_only;
    logic [7:0] pat;
    logic       exp_d;
    pat = 8'hA5;
    seed = 8'hA5; run_len = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_d = (c >= 2 && c <= 9) ? pat[9-c] : 1'b0;
      checks++;
      if (busy !== (c <= 10)) begin
        errors++; $display("FAIL load_busy cyc %0d got %b required %b", c, busy, (c <= 10));
      end
      checks++;
      if (lfsr_rst !== (c == 1)) begin
        errors++; $display("FAIL load_lfsr_rst cyc %0d got %b required %b", c, lfsr_rst, (c == 1));
      end
      checks++;
      if (lfsr_d !== exp_d || lfsr_fb !== 1'b0) begin
        errors++; $display("FAIL load_d cyc %0d got d=%b fb=%b required d=%b fb=0", c, lfsr_d, lfsr_fb, exp_d);
      end
      checks++;
      if (done !== (c == 11)) begin
        errors++; $display("FAIL load_done cyc %0d got %b required %b", c, done, (c == 11));
      end
      if (c == 11) begin
        checks++;
        if (result !== 8'hA5) begin
          errors++; $display("FAIL load_result got %h required a5", result);
        end
      end
      tick;
    end
    $display("load_only: seed=a5 run_len=0 result=%h", result);
  endtask

  task automatic test_full_period;
    int         dcyc;
    logic [7:0] res;
    logic       bd;
    do_op(8'h01, 16'd255, 400, dcyc, res, bd);
    checks++;
    if (dcyc !== 266) begin
      errors++; $display("FAIL period_done_cycle got %0d required 266", dcyc);
    end
    checks++;
    if (res !== 8'h01) begin
      errors++; $display("FAIL period_result got %h required 01", res);
    end
    checks++;
    if (bd !== 1'b0) begin
      errors++; $display("FAIL period_busy_at_done got %b required 0", bd);
    end
    $display("full_period: seed=01 run_len=255 done_cycle=%0d result=%h", dcyc, res);
    do_op(8'h01, 16'd1, 40, dcyc, res, bd);
    checks++;
    if (dcyc !== 12) begin
      errors++; $display("FAIL step1_done_cycle got %0d required 12", dcyc);
    end
    checks++;
    if (res !== 8'h02 || res !== ref_steps(8'h01, 1)) begin
      errors++; $display("FAIL step1_result got %h required 02", res);
    end
    $display("run_len_1: seed=01 done_cycle=%0d result=%h", dcyc, res);
  endtask

  task automatic test_zero_seed;
    logic [7:0] prev;
    prev = result;
    seed = 8'h00; run_len = 16'd5; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (seed_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_seed_err got err=%b busy=%b required err=1 busy=0", seed_err, busy);
    end
    for (int c = 2; c <= 14; c++) begin
      tick;
      checks++;
      if ({seed_err, busy, lfsr_rst, done} !== 4'b0) begin
        errors++; $display("FAIL zero_seed_idle cyc %0d got err/busy/rst/done=%b required 0000", c, {seed_err, busy, lfsr_rst, done});
      end
    end
    checks++;
    if (result !== prev) begin
      errors++; $display("FAIL zero_seed_result got %h required %h", result, prev);
    end
    $display("zero_seed: seed=00 rejected result=%h", result);
  endtask

  task automatic test_abort;
    logic [7:0] prev;
    int         dcyc;
    logic [7:0] res;
    logic       bd;
    prev = result;
    seed = 8'h3C; run_len = 16'd5; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick;
    // cycle 5 is the fourth load cycle
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || lfsr_d !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b d=%b required 0 0", busy, lfsr_d);
    end
    // new start in the cycle right after the abort
    do_op(8'h3C, 16'd3, 40, dcyc, res, bd);
    checks++;
    if (dcyc !== 14) begin
      errors++; $display("FAIL abort_restart_cycle got %0d required 14", dcyc);
    end
    checks++;
    if (res !== ref_steps(8'h3C, 3)) begin
      errors++; $display("FAIL abort_restart_result got %h required %h", res, ref_steps(8'h3C, 3));
    end
    $display("abort: prev_result=%h restart result=%h", prev, res);
  endtask

  task automatic test_abort_no_done;
    logic [7:0] prev;
    logic       saw_done;
    prev = result;
    saw_done = 1'b0;
    seed = 8'h77; run_len = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick;
    end
    checks++;
    if (saw_done !== 1'b0 || result !== prev) begin
      errors++; $display("FAIL abort_no_done got done_seen=%b result=%h required 0 %h", saw_done, result, prev);
    end
    $display("abort_no_done: result=%h", result);
  endtask

  task automatic test_reset_run;
    logic saw_done;
    saw_done = 1'b0;
    seed = 8'h81; run_len = 16'd20; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick;
    checks++;
    if (lfsr_fb !== 1'b1) begin
      errors++; $display("FAIL rst_run_in_run got fb=%b required 1", lfsr_fb);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy, done, seed_err, lfsr_rst, lfsr_d, lfsr_fb} !== 6'b0 || result !== 8'h00) begin
      errors++; $display("FAIL rst_run_outputs got %b result=%h required 000000 00",
                         {busy, done, seed_err, lfsr_rst, lfsr_d, lfsr_fb}, result);
    end
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL rst_run_activity got %b required 0", saw_done);
    end
    $display("reset_during_run: result=%h", result);
  endtask

  task automatic test_back_to_back;
    int         dcyc;
    logic [7:0] res;
    logic       bd;
    seed = 8'h5A; run_len = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 12) begin
        seed = 8'hFF; run_len = 16'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
      tick;
    end
    start = 1'b0;
    checks++;
    if (dcyc !== 15) begin
      errors++; $display("FAIL busy_start_cycle got %0d required 15", dcyc);
    end
    checks++;
    if (result !== ref_steps(8'h5A, 4)) begin
      errors++; $display("FAIL busy_start_result got %h required %h", result, ref_steps(8'h5A, 4));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_at_done got %b required 0", busy);
    end
    $display("start_while_busy: seed=5a result=%h", result);
    // start in cycle T+1 of the previous operation
    do_op(8'hC3, 16'd2, 40, dcyc, res, bd);
    checks++;
    if (dcyc !== 13 || res !== ref_steps(8'hC3, 2)) begin
      errors++; $display("FAIL back_to_back got cyc=%0d result=%h required 13 %h", dcyc, res, ref_steps(8'hC3, 2));
    end
    for (int c = 0; c < 5; c++) tick;
    checks++;
    if (result !== res) begin
      errors++; $display("FAIL result_hold got %h required %h", result, res);
    end
    $display("back_to_back: seed=c3 result=%h", res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = 8'h00; run_len = 16'd0;
    test_reset;
    test_load_only;
    test_full_period;
    test_zero_seed;
    test_abort;
    test_abort_no_done;
    test_reset_run;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencer for an 8-bit-class `simpleLFSR` instance. On `start` it clears the LFSR, shifts a seed in serially with feedback off, runs the LFSR with feedback on for a programmed number of cycles, then captures the final state and pulses `done`. It sits beside the LFSR and owns its `rst`, `d` and `fb` inputs. Nothing else drives those pins.

## Interface
- `LENGTH`, 8: LFSR width; must match the driven `simpleLFSR`.
- `CNT_W`, 16: width of the run-length counter.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `abort` in 1: cancel an operation in progress.
- `seed` in LENGTH: initial LFSR contents. Sampled on the accepted `start`.
- `run_len` in CNT_W: number of feedback cycles. Sampled on the accepted `start`.
- `lfsr_state` in LENGTH: `state` output of the LFSR.
- `lfsr_rst` out 1: drives the LFSR `rst`.
- `lfsr_d` out 1: drives the LFSR `d`.
- `lfsr_fb` out 1: drives the LFSR `fb`.
- `busy` out 1: high from the CLEAR state through the CAPTURE state.
- `done` out 1: one-cycle pulse when `result` updates.
- `result` out LENGTH: captured final LFSR state. Held until the next capture.
- `seed_err` out 1: one-cycle pulse when a `start` is rejected because `seed == 0`.

## Operation
- **LFSR contract:** when `fb = 0`, the LFSR shifts `d` into bit 0 each cycle, moving data toward the MSB. After LENGTH load cycles, `state == seed`.
- **FSM states:** IDLE → CLEAR → LOAD → RUN → CAPTURE → IDLE.
- **IDLE:** `lfsr_rst = 0`, `lfsr_fb = 0`, `lfsr_d = 0`, `busy = 0`.
  - `start = 1` and `seed != 0`: latch `seed` into the shift register and `run_len` into the counter; go to CLEAR.
  - `start = 1` and `seed == 0`: no transition; `seed_err = 1` next cycle. This guards against the all-zero lock-up state.
- **CLEAR:** 1 cycle; `lfsr_rst = 1`; go to LOAD with the bit counter at 0.
- **LOAD:** LENGTH cycles. In load cycle k (k = 0..LENGTH-1), `lfsr_d = seed_q[LENGTH-1-k]` (MSB first) and `lfsr_fb = 0`.
  - After the last cycle, go to RUN if `run_len_q != 0`; otherwise go to CAPTURE.
- **RUN:** exactly `run_len_q` cycles with `lfsr_fb = 1`, `lfsr_d = 0`. The counter decrements each cycle; at 1, go to CAPTURE.
- **CAPTURE:** 1 cycle; `lfsr_fb = 0`, `lfsr_d = 0`. At the end of the cycle, `result <= lfsr_state` and `done <= 1`; go to IDLE.
- **Start while busy:** `start` in any state other than IDLE is ignored. It is not queued and raises no error.
- **Abort:** `abort = 1` in CLEAR, LOAD or RUN moves to IDLE at the next edge. No `done`; `result` is unchanged.
  - `abort` in IDLE or CAPTURE has no effect; CAPTURE always completes.
- **Simultaneous start and abort in IDLE:** `start` wins.
- **Reset:** `rst` overrides everything, including mid-operation.
  - State → IDLE; `busy`, `done`, `seed_err`, `lfsr_d`, `lfsr_fb` → 0; `lfsr_rst` → 0.
  - `result` → 0.
  - Internal `seed_q`, `run_len_q` and counters → 0.
- **Width rules:** `run_len` up to 2^CNT_W−1; the counter is CNT_W bits and never wraps. The load counter is `$clog2(LENGTH)` bits.

## Timing
- Let edge 0 be the edge that samples an accepted `start`.
  - CLEAR: cycle 1.
  - LOAD: cycles 2..LENGTH+1.
  - RUN: cycles LENGTH+2..LENGTH+1+R, where R = `run_len`.
  - CAPTURE: cycle T = LENGTH+2+R.
  - `done` and the new `result`: cycle T+1.
- `busy` is high in cycles 1..T. It is low in cycle T+1, so a `start` in cycle T+1 is accepted.
- `seed_err` is high in cycle 1 after a rejected `start`.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Structure
- **Package `lfsr_ctrl_pkg`:** the `state_t` enum (IDLE, CLEAR, LOAD, RUN, CAPTURE) and the default `LENGTH`/`CNT_W` localparams.
- **No sub-module in the RTL:** the controller drives an external `simpleLFSR`.
- **Testbench:** instantiates `simpleLFSR` and `lfsr_seq_ctrl` side by side.

## Test plan
1. **Load only:** LENGTH=8, `seed = 8'hA5`, `run_len = 0` → `busy` high in cycles 1–10, `done` in cycle 11, `result = 8'hA5`. `lfsr_d` sequence over cycles 2–9 is 1,0,1,0,0,1,0,1.
2. **Full period:** `seed = 8'h01`, `run_len = 255`, maximal-length LFSR taps → `done` in cycle 266, `result = 8'h01`. Also check `run_len = 1`: `result` equals one feedback step of `8'h01`, compared against the bench reference model.
3. **Zero seed:** `start` with `seed = 0` → `seed_err` pulse in cycle 1; `busy` stays 0; `lfsr_rst` never asserted; no `done`.
4. **Abort:** `abort` in load cycle 4 → IDLE next edge; no `done`; `result` keeps its previous value. A new `start` in the following cycle completes normally.
5. **Reset during RUN:** `rst` asserted in cycle 15 of a `run_len = 20` operation → all outputs 0 on the next cycle; no `done`.
6. **Start while busy:** extra `start` pulses in cycles 3 and 12 with a different seed → ignored; `result` reflects only the first seed. Back-to-back `start` in cycle T+1 is accepted.
